// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells:
// FSM state encodings, counter-width helper and default operand width.
package serial_arith_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bit counter holds 0..WIDTH without wrapping inside one operation.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives, matching the adder cell.
// diff = a ^ b ^ bin, bout = (~a & b) | (~(a ^ b) & bin).
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic w_axb;
  logic w_na;
  logic w_nxb;
  logic w_gen;
  logic w_prop;

  xor u_x1 (w_axb, a, b);
  xor u_x2 (diff, w_axb, bin);
  not u_n1 (w_na, a);
  and u_a1 (w_gen, w_na, b);
  not u_n2 (w_nxb, w_axb);
  and u_a2 (w_prop, w_nxb, bin);
  or  u_o1 (bout, w_gen, w_prop);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per clock.
// One full_subtractor cell plus a borrow flop is reused for WIDTH cycles.
// Optional signed-overflow output is built when SERIAL_SUB_OVF_EN is defined.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | shifting operands through the cell, one bit per clock
// DONE  | one-cycle done pulse; a new start here goes straight to RUN
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_borrow_nxt;
  logic             w_load;
  logic             w_last;

  full_subtractor u_cell (
    .diff (w_d),
    .bout (w_borrow_nxt),
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .bin  (r_borrow)
  );

  assign w_last = (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; start is accepted in IDLE and DONE only.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand shift registers, borrow flop, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_a_sr   <= a;
      r_b_sr   <= b;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (r_state == RUN) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_diff   <= {w_d, r_diff[WIDTH-1:1]};
      r_borrow <= w_borrow_nxt;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) r_bout <= w_borrow_nxt;
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Signed overflow from the operand MSBs captured at load and the final result bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (r_state == RUN && w_last) begin
      r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH = 8).
// Define SERIAL_SUB_OVF_EN for the bench and the design together to cover ovf.
module tb_serial_subtractor;

  localparam int W     = 8;
  localparam int LIMIT = 50;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents start for exactly one rising edge; returns at the negedge after it.
  task automatic do_start(input logic [W-1:0] va, input logic [W-1:0] vb);
    @(negedge clk);
    start = 1'b1;
    a     = va;
    b     = vb;
    @(negedge clk);
    start = 1'b0;
    a     = 'x;
    b     = 'x;
  endtask

  // Counts negedges until done is seen, bounded by LIMIT.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < LIMIT);
  endtask

  task automatic test_reset();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL reset_diff got %h want 00", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL reset_bout got %b want 0", bout); end
`ifdef SERIAL_SUB_OVF_EN
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
  endtask

  task automatic test_basic();
    int n;
    do_start(8'h05, 8'h03);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_done(n);
    n_cmp++; if (n !== W) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", n, W); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy_done got %b want 0", busy); end
    n_cmp++; if (diff !== 8'h02) begin n_bad++; $display("FAIL basic_diff got %h want 02", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL basic_bout got %b want 0", bout); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
    n_cmp++; if (diff !== 8'h02) begin n_bad++; $display("FAIL basic_diff_hold got %h want 02", diff); end
  endtask

  task automatic test_borrow();
    int n;
    logic [W-1:0] va [3] = '{8'h03, 8'h00, 8'h42};
    logic [W-1:0] vb [3] = '{8'h05, 8'hFF, 8'h00};
    logic [W-1:0] vd [3] = '{8'hFE, 8'h01, 8'h42};
    logic         vo [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_start(va[i], vb[i]);
      wait_done(n);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL borrow_timeout[%0d] got %b want 1", i, done); end
      n_cmp++; if (diff !== vd[i]) begin n_bad++; $display("FAIL borrow_diff[%0d] got %h want %h", i, diff, vd[i]); end
      n_cmp++; if (bout !== vo[i]) begin n_bad++; $display("FAIL borrow_bout[%0d] got %b want %b", i, bout, vo[i]); end
    end
  endtask

  task automatic test_ignore_start();
    int n;
    do_start(8'h05, 8'h03);
    @(negedge clk);
    start = 1'b1;
    a     = 8'hAA;
    b     = 8'h11;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    n_cmp++; if (n !== W - 2) begin n_bad++; $display("FAIL ignore_latency got %0d want %0d", n, W - 2); end
    n_cmp++; if (diff !== 8'h02) begin n_bad++; $display("FAIL ignore_diff got %h want 02", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL ignore_bout got %b want 0", bout); end
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ignore_no_queue got busy %b want 0", busy); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(8'h05, 8'h03);
    wait_done(n);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b want 1", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL b2b_done got %b want 0", done); end
    wait_done(n);
    n_cmp++; if (n !== W) begin n_bad++; $display("FAIL b2b_latency got %0d want %0d", n, W); end
    n_cmp++; if (diff !== 8'h0F) begin n_bad++; $display("FAIL b2b_diff got %h want 0F", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL b2b_bout got %b want 0", bout); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_start(8'h03, 8'h05);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (diff !== 8'h00) begin n_bad++; $display("FAIL rstmid_diff got %h want 00", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL rstmid_bout got %b want 0", bout); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 3) rst_n = 1'b1;
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_no_done[%0d] got %b want 0", i, done); end
    end
    do_start(8'h20, 8'h01);
    wait_done(n);
    n_cmp++; if (n !== W) begin n_bad++; $display("FAIL rstmid_after_latency got %0d want %0d", n, W); end
    n_cmp++; if (diff !== 8'h1F) begin n_bad++; $display("FAIL rstmid_after_diff got %h want 1F", diff); end
    n_cmp++; if (bout !== 1'b0) begin n_bad++; $display("FAIL rstmid_after_bout got %b want 0", bout); end
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    int n;
    logic [W-1:0] va [3] = '{8'h80, 8'h7F, 8'h10};
    logic [W-1:0] vb [3] = '{8'h01, 8'hFF, 8'h01};
    logic [W-1:0] vd [3] = '{8'h7F, 8'h80, 8'h0F};
    logic         vo [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      do_start(va[i], vb[i]);
      wait_done(n);
      n_cmp++; if (diff !== vd[i]) begin n_bad++; $display("FAIL ovf_diff[%0d] got %h want %h", i, diff, vd[i]); end
      n_cmp++; if (ovf !== vo[i]) begin n_bad++; $display("FAIL ovf_flag[%0d] got %b want %b", i, ovf, vo[i]); end
    end
  endtask
`endif

  task automatic test_random();
    int n;
    logic [W-1:0] ca, cb, na, nb, ed;
    logic         eb;
    ca = W'($urandom);
    cb = W'($urandom);
    do_start(ca, cb);
    for (int i = 0; i < 1000; i++) begin
      wait_done(n);
      ed = ca - cb;
      eb = (ca < cb);
      n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL rand_timeout[%0d] got %b want 1", i, done); end
      n_cmp++; if (diff !== ed) begin n_bad++; $display("FAIL rand_diff[%0d] a=%h b=%h got %h want %h", i, ca, cb, diff, ed); end
      n_cmp++; if (bout !== eb) begin n_bad++; $display("FAIL rand_bout[%0d] a=%h b=%h got %b want %b", i, ca, cb, bout, eb); end
`ifdef SERIAL_SUB_OVF_EN
      begin
        int r;
        logic eo;
        r  = int'($signed(ca)) - int'($signed(cb));
        eo = (r > 127) || (r < -128);
        n_cmp++; if (ovf !== eo) begin n_bad++; $display("FAIL rand_ovf[%0d] a=%h b=%h got %b want %b", i, ca, cb, ovf, eo); end
      end
`endif
      if (i < 999) begin
        na    = W'($urandom);
        nb    = W'($urandom);
        start = 1'b1;
        a     = na;
        b     = nb;
        @(negedge clk);
        start = 1'b0;
        ca    = na;
        cb    = nb;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_borrow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
